// File: rtl/cpu_pkg.sv
// Shared types and widths for the core's memory-side blocks.
package cpu_pkg;

  localparam int WORD_W = 32;
  localparam int STRB_W = 4;

  // Who owns the SRAM response arriving this cycle.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    R_INST = 2'd1,
    R_DATA = 2'd2
  } owner_t;

endpackage

// File: rtl/arb_prio_grant.sv
// Data-first grant with a saturating starvation counter that forces an
// instruction fetch through after STARVE_LIMIT consecutive data wins.
module arb_prio_grant #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic inst_req,
  input  logic data_req,
  output logic gnt_inst,
  output logic gnt_data
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] cnt;
  logic [3:0] cnt_next;

  always_comb begin
    gnt_data = data_req && !(inst_req && (cnt == LIMIT));
    gnt_inst = inst_req && !gnt_data;
  end

  // Count only data wins that actually made a fetch wait.
  always_comb begin
    cnt_next = cnt;
    if (!inst_req || gnt_inst) begin
      cnt_next = 4'd0;
    end else if (gnt_data && (cnt != LIMIT)) begin
      cnt_next = cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= 4'd0;
    end else begin
      cnt <= cnt_next;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one synchronous single-port SRAM between fetch and load/store ports;
// the winner's read data is steered back one cycle after its grant.
module sram_arbiter
  import cpu_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              inst_req,
  input  logic [WORD_W-1:0] inst_addr,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [WORD_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [STRB_W-1:0] data_wstrb,
  input  logic [WORD_W-1:0] data_addr,
  input  logic [WORD_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [WORD_W-1:0] data_rdata,
  output logic              sram_en,
  output logic [STRB_W-1:0] sram_we,
  output logic [WORD_W-1:0] sram_addr,
  output logic [WORD_W-1:0] sram_wdata,
  input  logic [WORD_W-1:0] sram_rdata
);

  logic   gnt_inst;
  logic   gnt_data;
  owner_t owner_q;
  owner_t owner_d;

  arb_prio_grant #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_grant (
    .clk      (clk),
    .resetn   (resetn),
    .inst_req (inst_req),
    .data_req (data_req),
    .gnt_inst (gnt_inst),
    .gnt_data (gnt_data)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      owner_q <= IDLE;
    end else begin
      owner_q <= owner_d;
    end
  end

  always_comb begin
    owner_d = IDLE;
    if (gnt_data) begin
      owner_d = R_DATA;
    end else if (gnt_inst) begin
      owner_d = R_INST;
    end
  end

  // Grants are combinational, so reset must mask them to keep outputs quiet.
  always_comb begin
    inst_addr_ok = resetn && gnt_inst;
    data_addr_ok = resetn && gnt_data;
    sram_en      = 1'b0;
    sram_we      = '0;
    sram_addr    = '0;
    sram_wdata   = '0;
    if (data_addr_ok) begin
      sram_en    = 1'b1;
      sram_we    = data_wr ? data_wstrb : '0;
      sram_addr  = data_addr;
      sram_wdata = data_wdata;
    end else if (inst_addr_ok) begin
      sram_en    = 1'b1;
      sram_addr  = inst_addr;
    end
    inst_data_ok = (owner_q == R_INST);
    data_data_ok = (owner_q == R_DATA);
    inst_rdata   = inst_data_ok ? sram_rdata : '0;
    data_rdata   = data_data_ok ? sram_rdata : '0;
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a small behavioural SRAM whose
// word i is preloaded with 0xA5000000 | i.
module tb_sram_arbiter;

  logic        clk;
  logic        resetn;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        sram_en;
  logic [3:0]  sram_we;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;

  int checks;
  int errors;

  sram_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_wstrb   (data_wstrb),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .sram_en      (sram_en),
    .sram_we      (sram_we),
    .sram_addr    (sram_addr),
    .sram_wdata   (sram_wdata),
    .sram_rdata   (sram_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural synchronous SRAM: read data appears the cycle after sram_en.
  initial begin
    logic [31:0] mem [256];
    for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 | 32'(i);
    sram_rdata = '0;
    forever begin
      @(posedge clk);
      if (sram_en) begin
        if (sram_we == 4'b0) begin
          sram_rdata <= mem[sram_addr[9:2]];
        end else begin
          for (int b = 0; b < 4; b++)
            if (sram_we[b]) mem[sram_addr[9:2]][8*b +: 8] = sram_wdata[8*b +: 8];
        end
      end
    end
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's requests shortly after the edge, then let comb logic settle.
  task automatic apply_stimulus(input logic ir, input logic [31:0] ia,
                                input logic dr, input logic dw, input logic [3:0] ds,
                                input logic [31:0] da, input logic [31:0] dd);
    @(posedge clk);
    #1;
    inst_req   = ir;
    inst_addr  = ia;
    data_req   = dr;
    data_wr    = dw;
    data_wstrb = ds;
    data_addr  = da;
    data_wdata = dd;
    #1;
  endtask

  logic exp_dgnt [14] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1, 1, 1, 1};
  int   exp_cnt  [14] = '{0, 1, 2, 3, 4, 0, 1, 2, 3, 4, 0, 1, 2, 3};

  initial begin
    checks     = 0;
    errors     = 0;
    resetn     = 1'b0;
    inst_req   = 1'b1;
    inst_addr  = 32'h1c00_0000;
    data_req   = 1'b1;
    data_wr    = 1'b1;
    data_wstrb = 4'hf;
    data_addr  = 32'h0000_0100;
    data_wdata = 32'h1234_5678;
    #3;
    check_output("rst_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
    check_output("rst_data_addr_ok", 32'(data_addr_ok), 32'd0);
    check_output("rst_sram_en", 32'(sram_en), 32'd0);
    check_output("rst_sram_we", 32'(sram_we), 32'd0);
    check_output("rst_sram_addr", sram_addr, 32'd0);
    check_output("rst_sram_wdata", sram_wdata, 32'd0);
    check_output("rst_data_ok", 32'({inst_data_ok, data_data_ok}), 32'd0);
    check_output("rst_owner", 32'(dut.owner_q), 32'd0);
    check_output("rst_cnt", 32'(dut.u_grant.cnt), 32'd0);
    @(posedge clk);
    #1;
    resetn   = 1'b1;
    inst_req = 1'b0;
    data_req = 1'b0;
    data_wr  = 1'b0;

    // Instruction-only stream
    apply_stimulus(1, 32'h1c00_0000, 0, 0, 4'h0, 32'h0, 32'h0);
    check_output("if0_addr_ok", 32'(inst_addr_ok), 32'd1);
    check_output("if0_sram_en", 32'(sram_en), 32'd1);
    check_output("if0_sram_we", 32'(sram_we), 32'd0);
    check_output("if0_sram_addr", sram_addr, 32'h1c00_0000);
    apply_stimulus(1, 32'h1c00_0004, 0, 0, 4'h0, 32'h0, 32'h0);
    check_output("if1_addr_ok", 32'(inst_addr_ok), 32'd1);
    check_output("if1_sram_addr", sram_addr, 32'h1c00_0004);
    check_output("if0_data_ok", 32'(inst_data_ok), 32'd1);
    check_output("if0_rdata", inst_rdata, 32'hA500_0000);
    apply_stimulus(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
    check_output("gap_sram_en", 32'(sram_en), 32'd0);
    check_output("if1_data_ok", 32'(inst_data_ok), 32'd1);
    check_output("if1_rdata", inst_rdata, 32'hA500_0001);
    apply_stimulus(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
    check_output("gap_owner", 32'(dut.owner_q), 32'd0);
    check_output("gap_inst_ok", 32'(inst_data_ok), 32'd0);
    check_output("gap_inst_rdata", inst_rdata, 32'd0);

    // Collision with cnt = 0: load wins
    apply_stimulus(1, 32'h1c00_0008, 1, 0, 4'h0, 32'h0000_0100, 32'h0);
    check_output("col_data_addr_ok", 32'(data_addr_ok), 32'd1);
    check_output("col_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
    check_output("col_sram_addr", sram_addr, 32'h0000_0100);
    apply_stimulus(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
    check_output("col_data_ok", 32'(data_data_ok), 32'd1);
    check_output("col_rdata", data_rdata, 32'hA500_0040);
    check_output("col_inst_ok", 32'(inst_data_ok), 32'd0);
    check_output("col_cnt", 32'(dut.u_grant.cnt), 32'd1);

    // Partial store then read back
    apply_stimulus(0, 32'h0, 1, 1, 4'h3, 32'h0000_0200, 32'hAABB_CCDD);
    check_output("st_addr_ok", 32'(data_addr_ok), 32'd1);
    check_output("st_sram_we", 32'(sram_we), 32'h3);
    check_output("st_sram_wdata", sram_wdata, 32'hAABB_CCDD);
    check_output("st_cnt_clear", 32'(dut.u_grant.cnt), 32'd0);
    apply_stimulus(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
    check_output("st_data_ok", 32'(data_data_ok), 32'd1);
    apply_stimulus(0, 32'h0, 1, 0, 4'hf, 32'h0000_0200, 32'h0);
    check_output("ld_sram_we", 32'(sram_we), 32'd0);
    apply_stimulus(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
    check_output("ld_data_ok", 32'(data_data_ok), 32'd1);
    check_output("ld_rdata", data_rdata, 32'hA500_CCDD);

    // Starvation: both ports held continuously
    for (int k = 0; k < 14; k++) begin
      apply_stimulus(1, 32'h1c00_0010, 1, 0, 4'h0, 32'h0000_0104, 32'h0);
      check_output($sformatf("stv%0d_dgnt", k), 32'(data_addr_ok), 32'(exp_dgnt[k]));
      check_output($sformatf("stv%0d_ignt", k), 32'(inst_addr_ok), 32'(!exp_dgnt[k]));
      check_output($sformatf("stv%0d_cnt", k), 32'(dut.u_grant.cnt), 32'(exp_cnt[k]));
      if (k > 0) begin
        check_output($sformatf("stv%0d_dok", k), 32'(data_data_ok), 32'(exp_dgnt[k-1]));
        check_output($sformatf("stv%0d_iok", k), 32'(inst_data_ok), 32'(!exp_dgnt[k-1]));
        check_output($sformatf("stv%0d_rdata", k), exp_dgnt[k-1] ? data_rdata : inst_rdata,
                     exp_dgnt[k-1] ? 32'hA500_0041 : 32'hA500_0004);
      end
    end
    apply_stimulus(0, 32'h0, 1, 0, 4'h0, 32'h0000_0104, 32'h0);
    check_output("sat_cnt", 32'(dut.u_grant.cnt), 32'd4);
    check_output("sat_dgnt", 32'(data_addr_ok), 32'd1);
    apply_stimulus(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
    check_output("sat_cnt_clear", 32'(dut.u_grant.cnt), 32'd0);

    // Reset while a load is outstanding
    apply_stimulus(0, 32'h0, 1, 0, 4'h0, 32'h0000_0100, 32'h0);
    check_output("rm_addr_ok", 32'(data_addr_ok), 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    check_output("rm_addr_ok_rst", 32'(data_addr_ok), 32'd0);
    check_output("rm_sram_en_rst", 32'(sram_en), 32'd0);
    check_output("rm_sram_addr_rst", sram_addr, 32'd0);
    @(posedge clk);
    #1;
    check_output("rm_data_ok", 32'(data_data_ok), 32'd0);
    check_output("rm_owner", 32'(dut.owner_q), 32'd0);
    resetn   = 1'b1;
    data_req = 1'b0;
    apply_stimulus(0, 32'h0, 1, 0, 4'h0, 32'h0000_0100, 32'h0);
    check_output("rm_regrant", 32'(data_addr_ok), 32'd1);
    apply_stimulus(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
    check_output("rm_data_ok2", 32'(data_data_ok), 32'd1);
    check_output("rm_rdata2", data_rdata, 32'hA500_0040);
    apply_stimulus(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
    check_output("end_idle_ok", 32'({inst_data_ok, data_data_ok}), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
